// File: rtl/mm_pkg.sv
// Shared types and constants for the mm_engine matrix multiplier.
package mm_pkg;

   // Control FSM states.
   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_RD_A,
      S_RD_B,
      S_WR,
      S_DONE
   } state_t;

   // Codes driven on the index output to say which array is being accessed.
   localparam logic [1:0] IDX_A   = 2'd0;
   localparam logic [1:0] IDX_B   = 2'd1;
   localparam logic [1:0] IDX_HDR = 2'd2;
   localparam logic [1:0] IDX_C   = 2'd3;

endpackage

// File: rtl/mm_mac.sv
// Multiply-accumulate unit for mm_engine: extends both operands to 2*DW,
// multiplies, extends the product to AW and adds it to the accumulator.
// Build option MM_SAT_EN: clamp each accumulate to the AW range instead of
// wrapping, and report the clamp on clamp_o.
module mm_mac #(
   parameter int DW     = 20,
   parameter int AW     = 2 * DW,
   parameter int SIGNED = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr_i,
   input  logic          en_i,
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   output logic [AW-1:0] acc_o,
   output logic          clamp_o
);

   logic [2*DW-1:0] a_x, b_x, prod;
   logic [AW-1:0]   prod_x, sum, acc_q, acc_d;

   // Operand and product extension depend only on the signedness parameter.
   generate
      if (SIGNED != 0) begin : g_signed
         assign a_x    = {{DW{a_i[DW-1]}}, a_i};
         assign b_x    = {{DW{b_i[DW-1]}}, b_i};
         assign prod_x = AW'($signed(prod));
      end else begin : g_unsigned
         assign a_x    = {{DW{1'b0}}, a_i};
         assign b_x    = {{DW{1'b0}}, b_i};
         assign prod_x = AW'(prod);
      end
   endgenerate

   // Low 2*DW bits of the extended product are exact for both signednesses.
   assign prod  = a_x * b_x;
   assign sum   = acc_q + prod_x;
   assign acc_o = acc_q;

`ifdef MM_SAT_EN
   logic          ovf;
   logic [AW-1:0] lim;

   // Detect overflow of the wrapped sum and pick the limit it should clamp to.
   always_comb begin
      if (SIGNED != 0) begin
         ovf = (acc_q[AW-1] == prod_x[AW-1]) && (sum[AW-1] != acc_q[AW-1]);
         lim = acc_q[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      end else begin
         ovf = (sum < acc_q);
         lim = '1;
      end
   end
`endif

   // Next accumulator value: clear has priority over accumulate.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned and a latch is never inferred.
      acc_d   = acc_q;
      clamp_o = 1'b0;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = sum;
`ifdef MM_SAT_EN
         if (ovf) begin
            acc_d   = lim;
            clamp_o = 1'b1;
         end
`endif
      end
   end

   // Accumulator register.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every register
      // samples the pre-edge values regardless of block ordering.
      if (reset) acc_q <= '0;
      else       acc_q <= acc_d;
   end

endmodule

// File: rtl/mm_engine.sv
// Parametrised matrix multiplier C = A x B. Reads an M/N/P header and the
// elements of A and B through one read port, accumulates each C element in
// mm_mac and writes it out through the write port.
// Build option MM_SAT_EN: saturating accumulation with a sticky sat flag;
// without it accumulation wraps and sat stays 0.
module mm_engine
   import mm_pkg::*;
#(
   parameter int DW     = 20,
   parameter int IW     = 20,
   parameter int AW     = 2 * DW,
   parameter int SIGNED = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          read,
   output logic [1:0]    index,
   output logic [IW-1:0] i,
   output logic [IW-1:0] j,
   input  logic [DW-1:0] read_data,
   input  logic          read_valid,
   output logic          write,
   output logic [AW-1:0] write_data,
   input  logic          write_ready,
   output logic          finish,
   output logic          sat
);

   // Common width for comparing IW-wide counters against DW-wide dimensions.
   localparam int CW = (DW > IW) ? DW : IW;

   state_t        state_q, state_d;
   logic [1:0]    hdr_q, hdr_d;
   logic [DW-1:0] m_q, m_d, n_q, n_d, p_q, p_d, a_q, a_d;
   logic [IW-1:0] row_q, row_d, col_q, col_d, k_q, k_d;
   logic          sat_q, sat_d;
   logic          mac_clr, mac_en, mac_clamp;
   logic [AW-1:0] acc;
   logic          k_last, col_last, row_last;

   assign k_last   = (CW'(k_q)   == CW'(n_q) - CW'(1));
   assign col_last = (CW'(col_q) == CW'(p_q) - CW'(1));
   assign row_last = (CW'(row_q) == CW'(m_q) - CW'(1));

   mm_mac #(
      .DW     (DW),
      .AW     (AW),
      .SIGNED (SIGNED)
   ) u_mac (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (mac_clr),
      .en_i    (mac_en),
      .a_i     (a_q),
      .b_i     (read_data),
      .acc_o   (acc),
      .clamp_o (mac_clamp)
   );

   // Next-state, counter, dimension and MAC-control logic.
   always_comb begin
      state_d = state_q;
      hdr_d   = hdr_q;
      m_d     = m_q;
      n_d     = n_q;
      p_d     = p_q;
      a_d     = a_q;
      row_d   = row_q;
      col_d   = col_q;
      k_d     = k_q;
      sat_d   = sat_q | mac_clamp;
      mac_clr = 1'b0;
      mac_en  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_HDR;
               hdr_d   = 2'd0;
               sat_d   = 1'b0;
               mac_clr = 1'b1;
            end
         end
         S_HDR: begin
            if (read_valid) begin
               unique case (hdr_q)
                  2'd0:    begin m_d = read_data; hdr_d = 2'd1; end
                  2'd1:    begin n_d = read_data; hdr_d = 2'd2; end
                  default: begin
                     p_d   = read_data;
                     hdr_d = 2'd0;
                     row_d = '0;
                     col_d = '0;
                     k_d   = '0;
                     mac_clr = 1'b1;
                     if (m_q == '0 || n_q == '0 || read_data == '0) state_d = S_DONE;
                     else                                         state_d = S_RD_A;
                  end
               endcase
            end
         end
         S_RD_A: begin
            if (read_valid) begin
               a_d     = read_data;
               state_d = S_RD_B;
            end
         end
         S_RD_B: begin
            if (read_valid) begin
               mac_en = 1'b1;
               if (k_last) begin
                  state_d = S_WR;
               end else begin
                  k_d     = k_q + IW'(1);
                  state_d = S_RD_A;
               end
            end
         end
         S_WR: begin
            if (write_ready) begin
               mac_clr = 1'b1;
               k_d     = '0;
               if (col_last) begin
                  col_d = '0;
                  if (row_last) begin
                     state_d = S_DONE;
                  end else begin
                     row_d   = row_q + IW'(1);
                     state_d = S_RD_A;
                  end
               end else begin
                  col_d   = col_q + IW'(1);
                  state_d = S_RD_A;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, counter and dimension registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         hdr_q   <= '0;
         m_q     <= '0;
         n_q     <= '0;
         p_q     <= '0;
         a_q     <= '0;
         row_q   <= '0;
         col_q   <= '0;
         k_q     <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hdr_q   <= hdr_d;
         m_q     <= m_d;
         n_q     <= n_d;
         p_q     <= p_d;
         a_q     <= a_d;
         row_q   <= row_d;
         col_q   <= col_d;
         k_q     <= k_d;
         sat_q   <= sat_d;
      end
   end

   // Port outputs decoded from registered state and counters only.
   always_comb begin
      busy   = 1'b0;
      read   = 1'b0;
      write  = 1'b0;
      finish = 1'b0;
      index  = IDX_A;
      i      = '0;
      j      = '0;
      unique case (state_q)
         S_HDR:  begin busy = 1'b1; read = 1'b1; index = IDX_HDR; i = IW'(hdr_q); end
         S_RD_A: begin busy = 1'b1; read = 1'b1; index = IDX_A; i = row_q; j = k_q; end
         S_RD_B: begin busy = 1'b1; read = 1'b1; index = IDX_B; i = k_q; j = col_q; end
         S_WR:   begin busy = 1'b1; write = 1'b1; index = IDX_C; i = row_q; j = col_q; end
         S_DONE: finish = 1'b1;
         default: ;
      endcase
   end

   assign write_data = acc;
   assign sat        = sat_q;

endmodule

// File: doc/mm_engine.md
# mm_engine

Parametrised successor to the fixed-width matrix multiplier. Computes C = A × B on demand:
- reads the dimension header and the elements of A (M×N) and B (N×P) through a shared element read port;
- accumulates each C element in a multiply-accumulate unit;
- writes each C element out through a write port.

Unlike the fixed block, it adds a start/busy control, valid/ready stalls on both memory ports, selectable signedness and parametrised widths. It sits between the testbench or host memory model and any consumer of the C matrix.

## Interface
- DW, 20: element width of A and B and of header words.
- IW, 20: row/column index width.
- AW, 2*DW: accumulator and write_data width; must be ≥ 2*DW.
- SIGNED, 1: 1 = two's-complement elements and products; 0 = unsigned.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a computation; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until finish.
- read  out  1  read request.
- index  out  2  target of the current access: 0 = A, 1 = B, 2 = header, 3 = C write.
- i  out  IW  row address of the current access.
- j  out  IW  column address of the current access.
- read_data  in  DW  read return data.
- read_valid  in  1  read_data is valid this cycle; completes the read.
- write  out  1  write request.
- write_data  out  AW  C element being written.
- write_ready  in  1  write accepted this cycle.
- finish  out  1  one-cycle pulse after the last write is accepted.
- sat  out  1  sticky saturation flag for the current run.

## Operation
- States: IDLE, HDR, RD_A, RD_B, WR, DONE.
- Request signals are held stable until the matching handshake completes.

IDLE
- All request outputs low.
- start=1 → HDR, with i=0 and j=0.
- busy rises and sat clears on the same edge.

HDR
- read=1, index=2, j=0; i steps 0,1,2, latching M, N, P.
- Each header word takes one accepted read (read_valid=1).
- After P is latched:
  - M, N or P equal to 0 → DONE; no element accesses and no writes.
  - Otherwise → RD_A with row=0, col=0, k=0, acc=0.

RD_A
- read=1, index=0, i=row, j=k.
- On read_valid: latch a_reg, then → RD_B.

RD_B
- read=1, index=1, i=k, j=col.
- On read_valid: acc += extend(a_reg) × extend(read_data).
- If k==N−1 → WR; otherwise k++ and → RD_A.

WR
- write=1, index=3, i=row, j=col, write_data=acc.
- On write_ready: acc=0 and k=0, then:
  - col==P−1 and row==M−1 → DONE;
  - col==P−1 only → col=0, row++, → RD_A;
  - otherwise → col++, → RD_A.

DONE
- finish=1 for exactly one cycle, busy=0, → IDLE.

Arithmetic
- Product is formed at 2*DW bits, sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to AW, then added to acc.
- Overflow wraps modulo 2^AW, except as described under Configuration.

Boundary conditions
- start while busy: ignored.
- read_valid or write_ready outside a matching request: ignored.
- reset mid-run: in-flight access abandoned; all state and outputs return to reset values on that edge.
- Rows, columns and k never exceed M−1, P−1 and N−1 respectively; no wrap-around of i or j.

## Timing
- Reset values: state=IDLE; read, write, busy, finish and sat are 0; i, j, index, write_data, acc and all dimension registers are 0.
- Outputs are registered, or decoded from registered state only. No combinational path from read_valid or write_ready to any output.
- With read_valid and write_ready tied high:
  - HDR takes 3 cycles;
  - each C element takes 2N+1 cycles;
  - DONE takes 1 cycle;
  - total from start to finish is 3 + M·P·(2N+1) + 1 cycles.
- Each low cycle of read_valid or write_ready adds exactly one cycle.

## Configuration
- MM_SAT_EN defined:
  - each accumulate saturates to the representable AW range (signed or unsigned per SIGNED) instead of wrapping;
  - any clamp sets sat, which stays set until the next start or reset.
- MM_SAT_EN undefined: accumulation wraps; sat is tied to 0.

## Structure
- Package mm_pkg holds:
  - the state enum;
  - index codes IDX_A=0, IDX_B=1, IDX_HDR=2, IDX_C=3.
- Sub-module mm_mac:
  - contains the multiply, extension, accumulate, clear and saturation logic;
  - parameterised by DW, AW and SIGNED.
- The top level contains the FSM, counters and dimension registers.

## Test plan
- 2×2×2 test, SIGNED=1, no stalls:
  - A=[[1,2],[3,4]], B=[[5,6],[7,8]] → writes 19, 22, 43, 50 in row-major order;
  - finish pulses at cycle 3+4·5+1=24 after start.
- Negative operands, SIGNED=1:
  - A=[[−3]], B=[[7]] → write_data = −21, sign-extended to AW.
- Stalls:
  - with read_valid and write_ready toggling pseudo-randomly, results match the no-stall run;
  - i, j and index stay stable throughout each stall.
- Zero dimension:
  - header M=2, N=0, P=3 → no writes; finish pulses one cycle after the third header read.
- MM_SAT_EN, SIGNED=0, DW=4, AW=8, 1×2×1:
  - A=[15,15], B=[15,15] → write_data=255, sat=1.
  - Without the macro: write_data=194 (450 mod 256), sat=0.
- Reset and start during a run:
  - reset asserted during RD_B → next cycle shows IDLE reset values;
  - start pulsed while busy → no restart, results unchanged.
